// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer advanced by a 1 Hz tick strobe, with a one-cycle
// done strobe on expiry and an alarm held for ALARM_TICKS ticks.
module countdown_timer #(
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  localparam logic [7:0] ALARM_INIT = 8'(ALARM_TICKS);

  state_t      state;
  logic [7:0]  alarm_cnt;
  logic [15:0] dec_val;
  logic [15:0] preset_val;
  logic        count_nz;

  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [15:0] sanitise(input logic [7:0] m, input logic [7:0] s);
    logic [3:0] st;
    st = (s[7:4] > 4'd5) ? 4'd5 : s[7:4];
    return {clamp9(m[7:4]), clamp9(m[3:0]), st, clamp9(s[3:0])};
  endfunction

  // One-second BCD decrement; sec ones, sec tens and min ones borrow in turn.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          if (mt != 4'd0) begin
            mt = mt - 4'd1;
          end else begin
            mt = 4'd0;
          end
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign dec_val    = bcd_dec({min_bcd, sec_bcd});
  assign preset_val = sanitise(preset_min, preset_sec);
  assign count_nz   = ({min_bcd, sec_bcd} != 16'h0000);

  // Control FSM with strict strobe priority: clear > load > pause > start > tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      min_bcd   <= 8'h00;
      sec_bcd   <= 8'h00;
      running   <= 1'b0;
      done      <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= 8'd0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        min_bcd   <= 8'h00;
        sec_bcd   <= 8'h00;
        running   <= 1'b0;
        alarm     <= 1'b0;
        alarm_cnt <= 8'd0;
      end else if (load) begin
        if (state != RUN) begin
          state              <= IDLE;
          {min_bcd, sec_bcd} <= preset_val;
          running            <= 1'b0;
          alarm              <= 1'b0;
          alarm_cnt          <= 8'd0;
        end
      end else if (pause) begin
        if (state == RUN) begin
          state   <= PAUSED;
          running <= 1'b0;
        end
      end else if (start) begin
        if ((state == IDLE || state == PAUSED) && count_nz) begin
          state   <= RUN;
          running <= 1'b1;
        end
      end else if (tick) begin
        case (state)
          RUN: begin
            if (count_nz) begin
              {min_bcd, sec_bcd} <= dec_val;
              if (dec_val == 16'h0000) begin
                state     <= EXPIRED;
                running   <= 1'b0;
                done      <= 1'b1;
                alarm     <= 1'b1;
                alarm_cnt <= ALARM_INIT;
              end
            end
          end
          EXPIRED: begin
            if (alarm_cnt != 8'd0) begin
              alarm_cnt <= alarm_cnt - 8'd1;
              if (alarm_cnt == 8'd1) begin
                alarm <= 1'b0;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven scoreboard bench for countdown_timer (ALARM_TICKS = 2).
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, tick, start, pause, clear, load;
  logic [7:0] preset_min, preset_sec;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, done, alarm;

  countdown_timer #(.ALARM_TICKS(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
    .clear(clear), .load(load), .preset_min(preset_min), .preset_sec(preset_sec),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running), .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] N = 5'b00000, T = 5'b00001, S = 5'b00010,
                         P = 5'b00100, L = 5'b01000, C = 5'b10000;

  typedef struct {
    logic [4:0] ctl;
    logic [7:0] pm, ps, em, es;
    logic       er, ed, ea;
  } vec_t;

  typedef struct {
    logic [7:0] m, s;
    logic       r, d, a;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input logic [4:0] ctl, input logic [7:0] pm, input logic [7:0] ps,
                     input logic [7:0] em, input logic [7:0] es,
                     input logic er, input logic ed, input logic ea);
    vec_t v;
    v.ctl = ctl; v.pm = pm; v.ps = ps; v.em = em; v.es = es;
    v.er = er; v.ed = ed; v.ea = ea;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] ctl, input logic [7:0] pm, input logic [7:0] ps);
    {clear, load, pause, start, tick} = ctl;
    preset_min = pm;
    preset_sec = ps;
  endtask

  task automatic expect_out(input logic [7:0] m, input logic [7:0] s,
                            input logic r, input logic d, input logic a);
    exp_t e;
    e.m = m; e.s = s; e.r = r; e.d = d; e.a = a;
    sb.push_back(e);
  endtask

  task automatic check(input string name);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, no expected value", name);
    end else begin
      e = sb.pop_front();
      if (min_bcd !== e.m || sec_bcd !== e.s || running !== e.r ||
          done !== e.d || alarm !== e.a) begin
        n_err++;
        $display("FAIL %s: got %h:%h run=%b done=%b alarm=%b, expected %h:%h run=%b done=%b alarm=%b",
                 name, min_bcd, sec_bcd, running, done, alarm, e.m, e.s, e.r, e.d, e.a);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(N, 8'h00, 8'h00);

    //  ctl    pm     ps     em     es    run   done  alarm
    add(L,     8'h00, 8'h03, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    add(S,     8'h00, 8'h00, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    add(N,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    add(T,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    add(T,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(S,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // full borrow chain, load ignored in RUN, then 01:00 -> 00:59
    add(L,     8'h10, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
    add(S,     8'h00, 8'h00, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h09, 8'h59, 1'b1, 1'b0, 1'b0);
    add(L,     8'h01, 8'h00, 8'h09, 8'h59, 1'b1, 1'b0, 1'b0);
    add(P,     8'h00, 8'h00, 8'h09, 8'h59, 1'b0, 1'b0, 1'b0);
    add(L,     8'h01, 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
    add(S,     8'h00, 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h59, 1'b1, 1'b0, 1'b0);
    add(C,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // pause holds the count, resume to expiry
    add(L,     8'h00, 8'h05, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0);
    add(S,     8'h00, 8'h00, 8'h00, 8'h05, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h04, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
    add(P,     8'h00, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    add(S,     8'h00, 8'h00, 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
    // sanitising, and start at 00:00 ignored
    add(L,     8'hAA, 8'h7B, 8'h99, 8'h59, 1'b0, 1'b0, 1'b0);
    add(L,     8'h7F, 8'h6C, 8'h79, 8'h59, 1'b0, 1'b0, 1'b0);
    add(C,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(S,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // simultaneous strobes
    add(L,     8'h00, 8'h02, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
    add(S | T, 8'h00, 8'h00, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    add(P | T, 8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    add(S,     8'h00, 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    add(C | L, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    add(L,     8'h20, 8'h00, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0);
    add(S,     8'h00, 8'h00, 8'h20, 8'h00, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h19, 8'h59, 1'b1, 1'b0, 1'b0);
    add(C,     8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // reach 00:30 in RUN before the asynchronous reset sequence
    add(L,     8'h00, 8'h31, 8'h00, 8'h31, 1'b0, 1'b0, 1'b0);
    add(S,     8'h00, 8'h00, 8'h00, 8'h31, 1'b1, 1'b0, 1'b0);
    add(T,     8'h00, 8'h00, 8'h00, 8'h30, 1'b1, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    expect_out(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset_state");
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctl, vecs[i].pm, vecs[i].ps);
      expect_out(vecs[i].em, vecs[i].es, vecs[i].er, vecs[i].ed, vecs[i].ea);
      @(negedge clk);
      check($sformatf("vec%0d", i));
    end

    // Reset between clock edges clears outputs without waiting for an edge.
    drive(N, 8'h00, 8'h00);
    #2 reset = 1'b1;
    #1;
    expect_out(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    check("async_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive((i == 2) ? S : T, 8'h00, 8'h00);
      expect_out(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check($sformatf("post_reset%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD minutes:seconds countdown timer advanced by the one-cycle 1 Hz strobe from the pulse generator stage. Holds a loadable MM:SS preset, counts down while running, and on reaching 00:00 emits a one-cycle `done` strobe and a held `alarm`. Its BCD outputs feed the seven-segment display stage downstream; all controls arrive as pre-debounced one-cycle strobes.

## Interface
- `ALARM_TICKS`, default 10: number of `tick` strobes `alarm` stays high after expiry (1..255).
- `clk`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `tick`  in  1  one-cycle strobe, once per second, from the pulse generator.
- `start`  in  1  one-cycle strobe: begin or resume counting.
- `pause`  in  1  one-cycle strobe: suspend counting.
- `clear`  in  1  one-cycle strobe: zero the count and return to IDLE.
- `load`  in  1  one-cycle strobe: capture the preset.
- `preset_min`  in  8  two BCD digits, tens in [7:4], ones in [3:0].
- `preset_sec`  in  8  two BCD digits, tens in [7:4], ones in [3:0].
- `min_bcd`  out  8  current minutes, BCD.
- `sec_bcd`  out  8  current seconds, BCD.
- `running`  out  1  high while in RUN.
- `done`  out  1  one-cycle strobe on expiry.
- `alarm`  out  1  high for ALARM_TICKS ticks after expiry.

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED. Reset: IDLE, count 00:00, `running`=0, `done`=0, `alarm`=0, alarm counter 0.
- Control priority, evaluated each cycle: `clear` > `load` > `pause` > `start` > `tick`. A lower-priority event coinciding with a higher one is dropped.
- `clear` (any state): count 00:00, state IDLE, `alarm`=0.
- `load` (IDLE, PAUSED, EXPIRED): count takes the sanitised preset, state IDLE, `alarm`=0. Ignored in RUN.
- Sanitising: any digit >9 becomes 9; seconds tens >5 becomes 5. Example: preset 0x7F:0x6C loads 79:59.
- `start`: IDLE or PAUSED -> RUN if count != 00:00; ignored if count = 00:00. Ignored in RUN and EXPIRED.
- `pause`: RUN -> PAUSED. Ignored in every other state.
- `tick` in RUN decrements by one second with BCD borrow:
  - sec ones 0->9 borrows from sec tens.
  - sec tens 0->5 borrows from min ones.
  - min ones 0->9 borrows from min tens.
- The decrement that produces 00:00 also moves RUN -> EXPIRED, pulses `done`, sets `alarm`=1 and loads the alarm counter with ALARM_TICKS.
- `tick` in IDLE or PAUSED: no effect on the count.
- EXPIRED: each `tick` decrements the alarm counter, and `alarm` clears when it reaches 0. The count holds at 00:00. The state holds until `clear` or `load`.
- The count never wraps below 00:00. Maximum count is 99:59.

## Timing
- All outputs are registered. The count, `running`, `done` and `alarm` update on the `clk` edge that samples the triggering strobe, so they are visible one cycle after the strobe is high.
- `done` is high for exactly one cycle, coincident with the first cycle `sec_bcd`/`min_bcd` read 00:00 and `running`=0.
- `start` and `tick` in the same cycle from IDLE: enters RUN with no decrement. The first decrement happens on the next `tick`.
- `pause` and `tick` in the same cycle in RUN: enters PAUSED with no decrement.
- `reset` asserted mid-count: all state clears immediately and asynchronously. Counting resumes only after a new `load` and `start`.
- Back-to-back strobes on consecutive cycles are each honoured. There is no minimum spacing.

## Test plan
- Load 00:03, start, issue 3 ticks -> counts 00:02, 00:01, 00:00.
  - `done` high for 1 cycle after the third tick; `alarm` high; state EXPIRED.
  - With ALARM_TICKS=2, `alarm` drops after 2 further ticks.
- Load 10:00, start, 1 tick -> 09:59 (full borrow chain). Load 01:00, 1 tick while running -> 00:59.
- Load 00:05, start, 2 ticks, pause, 3 ticks -> holds 00:03. Start, 3 ticks -> 00:00 with `done`.
- Load 0xAA:0x7B -> 99:59. `start` with count 00:00 after `clear` -> `running` stays 0.
- Simultaneous events:
  - `start`+`tick` from IDLE at 00:02 -> `running`=1, count 00:02.
  - `pause`+`tick` in RUN -> no decrement.
  - `clear`+`load` -> 00:00, IDLE.
- Assert `reset` for one cycle at 00:30 in RUN -> outputs 00:00, `running`=0, `done`=0, `alarm`=0 immediately; later ticks have no effect.
